// File: rtl/dfdd_pkg.sv
// Shared types for the dfdd floating-point convolution pipeline.
package dfdd_pkg;

   localparam int FP16_W = 16;

   typedef logic [FP16_W-1:0] fp16_t;

   localparam fp16_t FP_ZERO = '0;

   typedef enum logic [0:0] {
      STREAM = 1'b0,
      FLUSH  = 1'b1
   } state_t;

endpackage

// File: rtl/window_generator_fp16_line_delay.sv
// Fixed delay of DEPTH enabled beats: a simple dual-port RAM walked by one wrapping pointer.
module line_delay #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 640
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [DATA_W-1:0] din_i,
   output logic [DATA_W-1:0] dout_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     ptr;

   // The slot about to be overwritten holds the beat written DEPTH pushes ago.
   assign dout_o = mem[ptr];

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         mem[ptr] <= din_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else if (en_i) begin
         ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
      end
   end

endmodule

// File: rtl/window_generator_fp16.sv
// Sliding-window source: turns a raster fp16 pixel stream into centred, edge-masked
// WINDOW_HEIGHT x WINDOW_WIDTH windows, one per image pixel.
module window_generator_fp16
   import dfdd_pkg::*;
#(
   parameter int EXP_WIDTH     = 5,
   parameter int FRAC_WIDTH    = 10,
   parameter int WINDOW_WIDTH  = 3,
   parameter int WINDOW_HEIGHT = 1,
   parameter int IMAGE_WIDTH   = 640,
   parameter int IMAGE_HEIGHT  = 480,
   parameter int FP_WIDTH_REG  = 1 + EXP_WIDTH + FRAC_WIDTH
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [FP_WIDTH_REG-1:0] data_i,
   input  logic                    valid_i,
   output logic [FP_WIDTH_REG-1:0] window_o [WINDOW_HEIGHT][WINDOW_WIDTH],
   output logic [15:0]             col_o,
   output logic [15:0]             row_o,
   output logic                    valid_o,
   output logic                    busy_o,
   output logic                    overflow_o
);

   localparam int HW = WINDOW_WIDTH / 2;
   localparam int HV = WINDOW_HEIGHT / 2;
   localparam int D  = HV * IMAGE_WIDTH + HW;

   localparam logic [FP_WIDTH_REG-1:0] PIX_ZERO = FP_WIDTH_REG'(FP_ZERO);

   state_t            state;
   logic [15:0]       in_col;
   logic [15:0]       in_row;
   logic [15:0]       ctr_col;
   logic [15:0]       ctr_row;
   logic [31:0]       fill_cnt;
   logic [31:0]       flush_cnt;
   logic              push;
   logic              emit;
   logic              last_beat;
   logic [FP_WIDTH_REG-1:0] push_pix;

   logic [FP_WIDTH_REG-1:0] tap        [WINDOW_HEIGHT];
   logic [FP_WIDTH_REG-1:0] col_sr_p0  [WINDOW_HEIGHT][WINDOW_WIDTH];
   logic [FP_WIDTH_REG-1:0] win_next   [WINDOW_HEIGHT][WINDOW_WIDTH];
   logic [FP_WIDTH_REG-1:0] win_masked [WINDOW_HEIGHT][WINDOW_WIDTH];

   // True when tap (i,j) of the window centred at (c,r) lies inside the image.
   function automatic logic in_image(input logic [15:0] c, input logic [15:0] r,
                                     input int i, input int j);
      logic signed [17:0] pc;
      logic signed [17:0] pr;
      pc = $signed({2'b00, c}) - 18'(HW) + 18'(j);
      pr = $signed({2'b00, r}) - 18'(HV) + 18'(i);
      return (pc >= 18'sd0) && (pc < 18'(IMAGE_WIDTH)) &&
             (pr >= 18'sd0) && (pr < 18'(IMAGE_HEIGHT));
   endfunction

   // FLUSH keeps the pipe moving with phantom zero pixels.
   assign push      = (state == FLUSH) || valid_i;
   assign push_pix  = (state == STREAM) ? data_i : PIX_ZERO;
   assign last_beat = (state == STREAM) && valid_i &&
                      (in_col == 16'(IMAGE_WIDTH - 1)) && (in_row == 16'(IMAGE_HEIGHT - 1));
   assign emit      = push && (fill_cnt == 32'(D));
   assign busy_o    = (state == FLUSH);

   assign tap[WINDOW_HEIGHT-1] = push_pix;

   for (genvar i = 0; i < WINDOW_HEIGHT - 1; i++) begin : g_line
      line_delay #(
         .DATA_W (FP_WIDTH_REG),
         .DEPTH  (IMAGE_WIDTH)
      ) u_line_delay (
         .clk_i  (clk_i),
         .rst_i  (rst_i),
         .en_i   (push),
         .din_i  (tap[i+1]),
         .dout_o (tap[i])
      );
   end

   for (genvar i = 0; i < WINDOW_HEIGHT; i++) begin : g_row
      for (genvar j = 0; j < WINDOW_WIDTH; j++) begin : g_col
         if (j == WINDOW_WIDTH - 1) begin : g_newest
            assign win_next[i][j] = tap[i];
         end else begin : g_shift
            assign win_next[i][j] = col_sr_p0[i][j+1];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WINDOW_HEIGHT; i++) begin
         for (int j = 0; j < WINDOW_WIDTH; j++) begin
            win_masked[i][j] = in_image(ctr_col, ctr_row, i, j) ? win_next[i][j] : PIX_ZERO;
         end
      end
   end

   // Stage p0: per-row column shift registers
   always_ff @(posedge clk_i) begin
      if (push) begin
         col_sr_p0 <= win_next;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= STREAM;
         in_col     <= '0;
         in_row     <= '0;
         fill_cnt   <= '0;
         flush_cnt  <= '0;
         ctr_col    <= '0;
         ctr_row    <= '0;
         overflow_o <= 1'b0;
      end else begin
         if (state == STREAM) begin
            if (valid_i) begin
               if (fill_cnt != 32'(D)) begin
                  fill_cnt <= fill_cnt + 32'd1;
               end
               if (last_beat) begin
                  in_col <= '0;
                  in_row <= '0;
                  if (D != 0) begin
                     state     <= FLUSH;
                     flush_cnt <= '0;
                  end
               end else if (in_col == 16'(IMAGE_WIDTH - 1)) begin
                  in_col <= '0;
                  in_row <= in_row + 16'd1;
               end else begin
                  in_col <= in_col + 16'd1;
               end
            end
         end else begin
            if (valid_i) begin
               overflow_o <= 1'b1;
            end
            // Re-arm the look-ahead fill so the next frame's first D beats stay silent.
            if (flush_cnt == 32'(D - 1)) begin
               state    <= STREAM;
               fill_cnt <= '0;
            end else begin
               flush_cnt <= flush_cnt + 32'd1;
            end
         end

         if (emit) begin
            if (ctr_col == 16'(IMAGE_WIDTH - 1)) begin
               ctr_col <= '0;
               ctr_row <= (ctr_row == 16'(IMAGE_HEIGHT - 1)) ? 16'd0 : ctr_row + 16'd1;
            end else begin
               ctr_col <= ctr_col + 16'd1;
            end
         end
      end
   end

   // Stage p1: registered window, centre position and valid
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o  <= 1'b0;
         col_o    <= '0;
         row_o    <= '0;
         window_o <= '{default: '0};
      end else begin
         valid_o <= emit;
         if (emit) begin
            window_o <= win_masked;
            col_o    <= ctr_col;
            row_o    <= ctr_row;
         end
      end
   end

endmodule

// File: tb/tb_window_generator_fp16.sv
// Directed bench: a 3x1 instance on a 4x2 image and a 3x3 instance on a 4x3 image.
module tb_window_generator_fp16;

   typedef struct packed {
      logic [15:0]  col;
      logic [15:0]  row;
      logic [47:0]  w;
   } reca_t;

   typedef struct packed {
      logic [15:0]  col;
      logic [15:0]  row;
      logic [143:0] w;
   } recb_t;

   localparam logic [15:0] PIX_A [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                         16'h4500, 16'h4600, 16'h4700, 16'h4800};
   localparam logic [47:0] EXP_A [8] = '{48'h0000_3C00_4000, 48'h3C00_4000_4200,
                                         48'h4000_4200_4400, 48'h4200_4400_0000,
                                         48'h0000_4500_4600, 48'h4500_4600_4700,
                                         48'h4600_4700_4800, 48'h4700_4800_0000};
   localparam logic [15:0] PIX_B [12] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                          16'h4500, 16'h4600, 16'h4700, 16'h4800,
                                          16'h4880, 16'h4900, 16'h4980, 16'h4A00};
   localparam logic [143:0] EXP_B00 =
      144'h0000_0000_0000_0000_3C00_4000_0000_4500_4600;
   localparam logic [143:0] EXP_B11 =
      144'h3C00_4000_4200_4500_4600_4700_4880_4900_4980;
   localparam logic [143:0] EXP_B32 =
      144'h4700_4800_0000_4980_4A00_0000_0000_0000_0000;

   logic        clk;
   logic        rst;
   logic [15:0] data_a, data_b;
   logic        valid_a, valid_b;
   logic [15:0] win_a [1][3];
   logic [15:0] win_b [3][3];
   logic [15:0] col_a, row_a, col_b, row_b;
   logic        vout_a, vout_b, busy_a, busy_b, ovf_a, ovf_b;

   int errors = 0;
   int checks = 0;

   reca_t capa[$];
   recb_t capb[$];
   reca_t tmp_a;
   recb_t tmp_b;

   window_generator_fp16 #(
      .WINDOW_WIDTH (3), .WINDOW_HEIGHT (1), .IMAGE_WIDTH (4), .IMAGE_HEIGHT (2)
   ) dut_a (
      .clk_i (clk), .rst_i (rst), .data_i (data_a), .valid_i (valid_a),
      .window_o (win_a), .col_o (col_a), .row_o (row_a), .valid_o (vout_a),
      .busy_o (busy_a), .overflow_o (ovf_a)
   );

   window_generator_fp16 #(
      .WINDOW_WIDTH (3), .WINDOW_HEIGHT (3), .IMAGE_WIDTH (4), .IMAGE_HEIGHT (3)
   ) dut_b (
      .clk_i (clk), .rst_i (rst), .data_i (data_b), .valid_i (valid_b),
      .window_o (win_b), .col_o (col_b), .row_o (row_b), .valid_o (vout_b),
      .busy_o (busy_b), .overflow_o (ovf_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [47:0] pack_a();
      return {win_a[0][0], win_a[0][1], win_a[0][2]};
   endfunction

   function automatic logic [143:0] pack_b();
      return {win_b[0][0], win_b[0][1], win_b[0][2],
              win_b[1][0], win_b[1][1], win_b[1][2],
              win_b[2][0], win_b[2][1], win_b[2][2]};
   endfunction

   always @(negedge clk) begin
      if (vout_a) begin
         tmp_a.col = col_a;
         tmp_a.row = row_a;
         tmp_a.w   = pack_a();
         capa.push_back(tmp_a);
      end
      if (vout_b) begin
         tmp_b.col = col_b;
         tmp_b.row = row_b;
         tmp_b.w   = pack_b();
         capb.push_back(tmp_b);
      end
   end

   // Entered at a negedge; returns at the next negedge with that edge's outputs visible.
   task automatic drive_a(input logic [15:0] d, input logic v);
      data_a  = d;
      valid_a = v;
      @(negedge clk);
      valid_a = 1'b0;
   endtask

   task automatic drive_b(input logic [15:0] d, input logic v);
      data_b  = d;
      valid_b = v;
      @(negedge clk);
      valid_b = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_frame_a(input string tag);
      checks++;
      if (capa.size() !== 8) begin
         errors++;
         $display("FAIL %s_count: got %0d windows, expected 8", tag, capa.size());
      end
      for (int k = 0; k < 8 && k < capa.size(); k++) begin
         checks++;
         if (capa[k].col !== 16'(k % 4) || capa[k].row !== 16'(k / 4) || capa[k].w !== EXP_A[k]) begin
            errors++;
            $display("FAIL %s_win%0d: got (%0d,%0d) %h, expected (%0d,%0d) %h",
                     tag, k, capa[k].col, capa[k].row, capa[k].w, k % 4, k / 4, EXP_A[k]);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle(2);
      checks++;
      if (vout_a !== 1'b0 || busy_a !== 1'b0 || ovf_a !== 1'b0 || col_a !== 16'd0 ||
          row_a !== 16'd0 || pack_a() !== 48'h0) begin
         errors++;
         $display("FAIL reset_a: got v=%b b=%b o=%b c=%0d r=%0d w=%h, expected all zero",
                  vout_a, busy_a, ovf_a, col_a, row_a, pack_a());
      end
      checks++;
      if (vout_b !== 1'b0 || busy_b !== 1'b0 || pack_b() !== 144'h0) begin
         errors++;
         $display("FAIL reset_b: got v=%b b=%b w=%h, expected all zero", vout_b, busy_b, pack_b());
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_stream();
      capa.delete();
      drive_a(PIX_A[0], 1'b1);
      checks++;
      if (vout_a !== 1'b0) begin
         errors++;
         $display("FAIL stream_first_beat_valid: got %b, expected 0", vout_a);
      end
      drive_a(PIX_A[1], 1'b1);
      checks++;
      if (vout_a !== 1'b1 || col_a !== 16'd0 || row_a !== 16'd0 || pack_a() !== EXP_A[0]) begin
         errors++;
         $display("FAIL stream_latency: got v=%b (%0d,%0d) %h, expected v=1 (0,0) %h",
                  vout_a, col_a, row_a, pack_a(), EXP_A[0]);
      end
      for (int k = 2; k < 8; k++) drive_a(PIX_A[k], 1'b1);
      idle(3);
      check_frame_a("stream");
   endtask

   task automatic test_flush();
      capa.delete();
      for (int k = 0; k < 8; k++) drive_a(PIX_A[k], 1'b1);
      checks++;
      if (busy_a !== 1'b1 || pack_a() !== EXP_A[6]) begin
         errors++;
         $display("FAIL flush_enter: got busy=%b w=%h, expected busy=1 w=%h", busy_a, pack_a(), EXP_A[6]);
      end
      idle(1);
      checks++;
      if (busy_a !== 1'b0 || vout_a !== 1'b1 || col_a !== 16'd3 || row_a !== 16'd1 ||
          pack_a() !== 48'h4700_4800_0000) begin
         errors++;
         $display("FAIL flush_last: got busy=%b v=%b (%0d,%0d) %h, expected busy=0 v=1 (3,1) 470048000000",
                  busy_a, vout_a, col_a, row_a, pack_a());
      end
      idle(1);
      checks++;
      if (vout_a !== 1'b0 || ovf_a !== 1'b0) begin
         errors++;
         $display("FAIL flush_done: got v=%b ovf=%b, expected 0 0", vout_a, ovf_a);
      end
      idle(2);
      check_frame_a("flush");
   endtask

   task automatic test_window_3x3();
      int busy_cnt;
      capb.delete();
      for (int k = 0; k < 12; k++) begin
         drive_b(PIX_B[k], 1'b1);
         if (k == 4) begin
            checks++;
            if (vout_b !== 1'b0) begin
               errors++;
               $display("FAIL w3x3_early_valid: got %b, expected 0", vout_b);
            end
         end
         if (k == 5) begin
            checks++;
            if (vout_b !== 1'b1 || col_b !== 16'd0 || row_b !== 16'd0 || pack_b() !== EXP_B00) begin
               errors++;
               $display("FAIL w3x3_first: got v=%b (%0d,%0d) %h, expected v=1 (0,0) %h",
                        vout_b, col_b, row_b, pack_b(), EXP_B00);
            end
         end
      end
      busy_cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (busy_b) busy_cnt++;
         @(negedge clk);
      end
      checks++;
      if (busy_cnt !== 5) begin
         errors++;
         $display("FAIL w3x3_busy_cycles: got %0d, expected 5", busy_cnt);
      end
      checks++;
      if (capb.size() !== 12) begin
         errors++;
         $display("FAIL w3x3_count: got %0d, expected 12", capb.size());
      end else begin
         for (int k = 0; k < 12; k++) begin
            checks++;
            if (capb[k].col !== 16'(k % 4) || capb[k].row !== 16'(k / 4)) begin
               errors++;
               $display("FAIL w3x3_pos%0d: got (%0d,%0d), expected (%0d,%0d)",
                        k, capb[k].col, capb[k].row, k % 4, k / 4);
            end
         end
         checks++;
         if (capb[5].w !== EXP_B11) begin
            errors++;
            $display("FAIL w3x3_centre: got %h, expected %h", capb[5].w, EXP_B11);
         end
         checks++;
         if (capb[11].w !== EXP_B32) begin
            errors++;
            $display("FAIL w3x3_corner: got %h, expected %h", capb[11].w, EXP_B32);
         end
      end
   endtask

   task automatic test_gaps();
      logic exp_v;
      capa.delete();
      for (int k = 0; k < 8; k++) begin
         drive_a(PIX_A[k], 1'b1);
         exp_v = (k >= 1);
         checks++;
         if (vout_a !== exp_v) begin
            errors++;
            $display("FAIL gaps_beat%0d_valid: got %b, expected %b", k, vout_a, exp_v);
         end
         drive_a(16'hDEAD, 1'b0);
         exp_v = (k == 7);
         checks++;
         if (vout_a !== exp_v) begin
            errors++;
            $display("FAIL gaps_idle%0d_valid: got %b, expected %b", k, vout_a, exp_v);
         end
      end
      idle(3);
      check_frame_a("gaps");
   endtask

   task automatic test_overflow();
      capa.delete();
      for (int k = 0; k < 8; k++) drive_a(PIX_A[k], 1'b1);
      drive_a(16'h1234, 1'b1);
      checks++;
      if (ovf_a !== 1'b1 || vout_a !== 1'b1 || pack_a() !== 48'h4700_4800_0000) begin
         errors++;
         $display("FAIL ovf_set: got ovf=%b v=%b w=%h, expected ovf=1 v=1 w=470048000000",
                  ovf_a, vout_a, pack_a());
      end
      idle(4);
      checks++;
      if (ovf_a !== 1'b1 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky: got ovf=%b busy=%b, expected 1 0", ovf_a, busy_a);
      end
      check_frame_a("ovf");
   endtask

   task automatic test_reset_midframe();
      drive_a(16'h7BFF, 1'b1);
      drive_a(16'h7BFE, 1'b1);
      drive_a(16'h7BFD, 1'b1);
      rst = 1'b1;
      #2;
      checks++;
      if (vout_a !== 1'b0 || busy_a !== 1'b0 || ovf_a !== 1'b0 || col_a !== 16'd0 ||
          row_a !== 16'd0 || pack_a() !== 48'h0) begin
         errors++;
         $display("FAIL midrst_outputs: got v=%b b=%b o=%b c=%0d r=%0d w=%h, expected all zero",
                  vout_a, busy_a, ovf_a, col_a, row_a, pack_a());
      end
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      capa.delete();
      for (int k = 0; k < 8; k++) drive_a(PIX_A[k], 1'b1);
      idle(3);
      check_frame_a("midrst");
   endtask

   initial begin
      rst     = 1'b1;
      data_a  = '0;
      data_b  = '0;
      valid_a = 1'b0;
      valid_b = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_flush();
      test_window_3x3();
      test_gaps();
      test_overflow();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
